// File: rtl/div_ctrl.sv
// div_ctrl: sequencing controller between the EX stage and a multi-cycle
// divider. It latches operands, holds the pipeline while the divider
// works, captures {remainder, quotient} into HI/LO and handles flush
// (annul window of CANCEL_CYCLES) and reset.
// Optional feature: define DIV_ZERO_TRAP_EN to short-circuit requests with a
// zero divisor straight to DONE with div_zero_o set and HI/LO untouched.
module div_ctrl #(
  parameter int CANCEL_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        div_req_i,
  input  logic        div_signed_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        flush_i,
  input  logic        stall_after_i,
  output logic        div_start_o,
  output logic        div_annul_o,
  output logic        div_signed_o,
  output logic [31:0] div_op1_o,
  output logic [31:0] div_op2_o,
  input  logic [63:0] div_result_i,
  input  logic        div_ready_i,
  output logic        stallreq_o,
  output logic        hilo_we_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        div_zero_o
);

  localparam int CW = (CANCEL_CYCLES > 1) ? $clog2(CANCEL_CYCLES) : 1;
  localparam logic [CW-1:0] CANCEL_LAST = CW'(CANCEL_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE, CANCEL} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cancel_cnt;
  logic          latch_ops;
  logic          capture;
  logic          zero_div;

`ifdef DIV_ZERO_TRAP_EN
  assign zero_div = (opdata2_i == 32'd0);
`else
  assign zero_div = 1'b0;
`endif

  // Next-state decode and the handshake outputs, all derived from the current state
  always_comb begin
    state_nxt   = state;
    stallreq_o  = 1'b0;
    div_start_o = 1'b0;
    div_annul_o = 1'b0;
    hilo_we_o   = 1'b0;
    latch_ops   = 1'b0;
    capture     = 1'b0;
    case (state)
      IDLE: begin
        if (div_req_i && !flush_i) begin
          stallreq_o = 1'b1;
          latch_ops  = 1'b1;
          state_nxt  = zero_div ? DONE : BUSY;
        end
      end
      BUSY: begin
        stallreq_o  = 1'b1;
        div_start_o = 1'b1;
        if (flush_i) begin
          state_nxt = CANCEL;
        end else if (div_ready_i) begin
          capture   = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        hilo_we_o = !flush_i && !div_zero_o;
        if (flush_i || !stall_after_i) begin
          state_nxt = IDLE;
        end
      end
      CANCEL: begin
        div_annul_o = 1'b1;
        if (cancel_cnt == CANCEL_LAST) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register plus the annul-window counter, which only runs in CANCEL
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cancel_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == CANCEL) begin
        cancel_cnt <= cancel_cnt + 1'b1;
      end else begin
        cancel_cnt <= '0;
      end
    end
  end

  // Operands are frozen at request time so the divider sees stable inputs
  always_ff @(posedge clk) begin
    if (rst) begin
      div_signed_o <= 1'b0;
      div_op1_o    <= '0;
      div_op2_o    <= '0;
    end else if (latch_ops) begin
      div_signed_o <= div_signed_i;
      div_op1_o    <= opdata1_i;
      div_op2_o    <= opdata2_i;
    end
  end

  // HI/LO capture of {remainder, quotient} when the divider reports ready
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_o <= '0;
      lo_o <= '0;
    end else if (capture) begin
      hi_o <= div_result_i[63:32];
      lo_o <= div_result_i[31:0];
    end
  end

`ifdef DIV_ZERO_TRAP_EN
  // Zero-divisor flag: set by a trapped request, cleared when DONE is left
  always_ff @(posedge clk) begin
    if (rst) begin
      div_zero_o <= 1'b0;
    end else if (latch_ops) begin
      div_zero_o <= zero_div;
    end else if (state == DONE && state_nxt == IDLE) begin
      div_zero_o <= 1'b0;
    end
  end
`else
  assign div_zero_o = 1'b0;
`endif

endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: scoreboard bench for div_ctrl with a behavioural divider
// whose latency is adjustable per test.
module tb_div_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        div_req_i, div_signed_i, flush_i, stall_after_i;
  logic [31:0] opdata1_i, opdata2_i;
  logic        div_start_o, div_annul_o, div_signed_o;
  logic [31:0] div_op1_o, div_op2_o;
  logic [63:0] div_result_i;
  logic        div_ready_i;
  logic        stallreq_o, hilo_we_o, div_zero_o;
  logic [31:0] hi_o, lo_o;

  int          asserts = 0;
  int          fails = 0;
  int          lat = 5;
  int          div_cnt = 0;
  int          start_pulses = 0;
  logic        prev_we = 1'b0;
  logic        prev_start = 1'b0;
  logic [63:0] exp_q[$];

  div_ctrl #(.CANCEL_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .div_req_i(div_req_i), .div_signed_i(div_signed_i),
    .opdata1_i(opdata1_i), .opdata2_i(opdata2_i), .flush_i(flush_i),
    .stall_after_i(stall_after_i), .div_start_o(div_start_o),
    .div_annul_o(div_annul_o), .div_signed_o(div_signed_o),
    .div_op1_o(div_op1_o), .div_op2_o(div_op2_o), .div_result_i(div_result_i),
    .div_ready_i(div_ready_i), .stallreq_o(stallreq_o), .hilo_we_o(hilo_we_o),
    .hi_o(hi_o), .lo_o(lo_o), .div_zero_o(div_zero_o)
  );

  // 10-unit clock
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    asserts++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Reference divider arithmetic, returns {remainder, quotient}
  function automatic logic [63:0] divModel(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    int sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      sa = a; sb = b;
      q = sa / sb; r = sa % sb;
      return {r[31:0], q[31:0]};
    end
    return {a % b, a / b};
  endfunction

  // Behavioural divider: raises ready after lat cycles of continuous start
  always @(negedge clk) begin
    if (div_start_o) begin
      div_cnt++;
      if (div_cnt >= lat) begin
        div_ready_i  = 1'b1;
        div_result_i = divModel(div_signed_o, div_op1_o, div_op2_o);
      end else begin
        div_ready_i = 1'b0;
      end
    end else begin
      div_cnt     = 0;
      div_ready_i = 1'b0;
    end
  end

  // Scoreboard: each new HI/LO write pops one expected result
  always @(negedge clk) begin
    logic [63:0] e;
    #1;
    if (div_start_o && !prev_start) start_pulses++;
    if (hilo_we_o && !prev_we) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_hilo_we", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        checkOutput("hi", {32'd0, hi_o}, {32'd0, e[63:32]});
        checkOutput("lo", {32'd0, lo_o}, {32'd0, e[31:0]});
      end
    end
    if (hilo_we_o) checkOutput("stallreq_in_done", {63'd0, stallreq_o}, 64'd0);
    prev_we    = hilo_we_o;
    prev_start = div_start_o;
  end

  // Presents one request for a single cycle; optionally records its result
  task automatic applyStimulus(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                               input bit push, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    div_req_i    = 1'b1;
    div_signed_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    #1;
    checkOutput("stallreq_on_req", {63'd0, stallreq_o}, 64'd1);
    if (push) exp_q.push_back({exp_hi, exp_lo});
    @(negedge clk);
    div_req_i = 1'b0;
    #1;
  endtask

  // Waits (bounded) for the first DONE cycle; stallreq must hold meanwhile
  task automatic waitDone(input int maxc);
    int n = 0;
    while (!hilo_we_o && n < maxc) begin
      checkOutput("stallreq_busy", {63'd0, stallreq_o}, 64'd1);
      @(negedge clk);
      #1;
      n++;
    end
    if (!hilo_we_o) checkOutput("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_start"}, {63'd0, div_start_o}, 64'd0);
    checkOutput({tag, "_annul"}, {63'd0, div_annul_o}, 64'd0);
    checkOutput({tag, "_signed"}, {63'd0, div_signed_o}, 64'd0);
    checkOutput({tag, "_ops"}, {div_op1_o, div_op2_o}, 64'd0);
    checkOutput({tag, "_we"}, {63'd0, hilo_we_o}, 64'd0);
    checkOutput({tag, "_hilo"}, {hi_o, lo_o}, 64'd0);
    checkOutput({tag, "_zero"}, {63'd0, div_zero_o}, 64'd0);
    checkOutput({tag, "_stallreq"}, {63'd0, stallreq_o}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int p0, annul_cnt, n;
    rst = 1'b1; div_req_i = 1'b0; div_signed_i = 1'b0; opdata1_i = '0; opdata2_i = '0;
    flush_i = 1'b0; stall_after_i = 1'b0; div_ready_i = 1'b0; div_result_i = '0;

    repeat (3) @(negedge clk);
    #1;
    checkAllZero("reset");
    @(negedge clk);
    rst = 1'b0;

    // DIVU 100/7
    $display("[TB] DIVU 100/7");
    lat = 5;
    p0 = start_pulses;
    @(negedge clk);
    applyStimulus(1'b0, 32'd100, 32'd7, 1, 32'h2, 32'hE);
    checkOutput("start_busy", {63'd0, div_start_o}, 64'd1);
    checkOutput("op1", {32'd0, div_op1_o}, 64'd100);
    checkOutput("op2", {32'd0, div_op2_o}, 64'd7);
    waitDone(50);
    @(negedge clk);
    #1;
    checkOutput("we_one_cycle", {63'd0, hilo_we_o}, 64'd0);
    checkOutput("pulses_100_7", 64'(start_pulses - p0), 64'd1);

    // DIV -7/2
    $display("[TB] DIV -7/2");
    @(negedge clk);
    applyStimulus(1'b1, 32'hFFFFFFF9, 32'd2, 1, 32'hFFFFFFFF, 32'hFFFFFFFD);
    checkOutput("signed_latched", {63'd0, div_signed_o}, 64'd1);
    waitDone(50);
    @(negedge clk);

    // Flush ten cycles into BUSY, request held through the annul window
    $display("[TB] flush in BUSY");
    lat = 20;
    applyStimulus(1'b0, 32'd1000, 32'd3, 0, 32'd0, 32'd0);
    repeat (9) @(negedge clk);
    flush_i = 1'b1;
    #1;
    checkOutput("stallreq_flush", {63'd0, stallreq_o}, 64'd1);
    @(negedge clk);
    flush_i = 1'b0;
    lat = 5;
    div_req_i = 1'b1; div_signed_i = 1'b0; opdata1_i = 32'd20; opdata2_i = 32'd3;
    exp_q.push_back({32'd2, 32'd6});
    annul_cnt = 0;
    n = 0;
    #1;
    while (!div_start_o && n < 20) begin
      if (div_annul_o) begin
        annul_cnt++;
        checkOutput("stallreq_cancel", {63'd0, stallreq_o}, 64'd0);
        checkOutput("we_cancel", {63'd0, hilo_we_o}, 64'd0);
      end
      @(negedge clk);
      #1;
      n++;
    end
    div_req_i = 1'b0;
    checkOutput("annul_cycles", 64'(annul_cnt), 64'd2);
    checkOutput("restart_after_cancel", {63'd0, div_start_o}, 64'd1);
    waitDone(50);
    @(negedge clk);

    // stall_after held for five DONE cycles, then back-to-back 9/3
    $display("[TB] stall_after in DONE");
    stall_after_i = 1'b1;
    p0 = start_pulses;
    applyStimulus(1'b0, 32'd77, 32'd7, 1, 32'd0, 32'd11);
    waitDone(50);
    for (int k = 1; k <= 6; k++) begin
      checkOutput("we_held", {63'd0, hilo_we_o}, 64'd1);
      checkOutput("hilo_held", {hi_o, lo_o}, {32'd0, 32'd11});
      checkOutput("no_start_done", {63'd0, div_start_o}, 64'd0);
      @(negedge clk);
      if (k == 5) stall_after_i = 1'b0;
      #1;
    end
    checkOutput("done_released", {63'd0, hilo_we_o}, 64'd0);
    checkOutput("pulses_stall", 64'(start_pulses - p0), 64'd1);
    applyStimulus(1'b0, 32'd9, 32'd3, 1, 32'd0, 32'd3);
    checkOutput("start_b2b", {63'd0, div_start_o}, 64'd1);
    waitDone(50);
    @(negedge clk);

    // Zero divisor
    $display("[TB] DIVU 5/0");
    p0 = start_pulses;
`ifdef DIV_ZERO_TRAP_EN
    applyStimulus(1'b0, 32'd5, 32'd0, 0, 32'd0, 32'd0);
    checkOutput("zero_flag", {63'd0, div_zero_o}, 64'd1);
    checkOutput("zero_no_start", {63'd0, div_start_o}, 64'd0);
    checkOutput("zero_no_we", {63'd0, hilo_we_o}, 64'd0);
    checkOutput("zero_hilo_kept", {hi_o, lo_o}, {32'd0, 32'd3});
    @(negedge clk);
    #1;
    checkOutput("zero_flag_clear", {63'd0, div_zero_o}, 64'd0);
    checkOutput("zero_pulses", 64'(start_pulses - p0), 64'd0);
`else
    applyStimulus(1'b0, 32'd5, 32'd0, 1, 32'd0, 32'd0);
    checkOutput("zero_start", {63'd0, div_start_o}, 64'd1);
    waitDone(50);
    checkOutput("zero_flag_off", {63'd0, div_zero_o}, 64'd0);
    checkOutput("zero_pulses", 64'(start_pulses - p0), 64'd1);
    @(negedge clk);
`endif

    // Reset four cycles into BUSY, then DIVU 50/5
    $display("[TB] reset in BUSY");
    lat = 20;
    @(negedge clk);
    applyStimulus(1'b0, 32'd123, 32'd4, 0, 32'd0, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    checkAllZero("rst_busy");
    rst = 1'b0;
    lat = 5;
    @(negedge clk);
    applyStimulus(1'b0, 32'd50, 32'd5, 1, 32'd0, 32'd10);
    checkOutput("start_after_rst", {63'd0, div_start_o}, 64'd1);
    waitDone(50);
    @(negedge clk);
    #2;
    checkOutput("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
